// File: rtl/vocab_writer.sv
`default_nettype none
// ============================================================================
// Module   : vocab_writer
// Purpose  : Write side of the vocabulary memory. Packs a valid/ready
//            character stream into fixed-width entries (first char in the
//            most-significant byte, zero padded), appends each entry at the
//            current end address and publishes token id and entry count.
// Options  : define VOCAB_WRITER_STRICT_LEN_EN to drop over-long words instead
//            of truncating and writing them.
// Revision : 1.0 - initial release
// ============================================================================
module vocab_writer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_char,
  input  logic                              in_last,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0] mem_wdata,
  output logic                              tok_valid,
  output logic [ADDR_WIDTH-1:0]             tok_id,
  output logic [ADDR_WIDTH:0]               vocab_count,
  output logic                              vocab_full,
  output logic                              overflow,
  output logic                              trunc,
  output logic                              null_drop
);

  localparam int EW = WORD_LENGTH * DATA_WIDTH;
  localparam int IW = $clog2(WORD_LENGTH + 1);
  localparam logic [IW-1:0]       C_WL       = IW'(WORD_LENGTH);
  localparam logic [ADDR_WIDTH:0] C_CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_PACK  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         buf_q, buf_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  tpend_q, tpend_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  null_q, null_d;
  logic                  ovf_q, ovf_d;
  logic                  trs_q, trs_d;

  logic                  w_accept;
  logic [EW-1:0]         w_buf_ins;

  assign in_ready    = (state_q != S_WRITE);
  assign w_accept    = in_valid && in_ready;
  assign mem_we      = (state_q == S_WRITE);
  assign mem_addr    = cnt_q[ADDR_WIDTH-1:0];
  assign mem_wdata   = buf_q;
  assign tok_valid   = (state_q == S_WRITE);
  assign tok_id      = cnt_q[ADDR_WIDTH-1:0];
  assign vocab_count = cnt_q;
  assign vocab_full  = (cnt_q == C_CAPACITY);
  assign overflow    = ovf_q;
  assign null_drop   = null_q;
  // Truncated-and-written words flag during the write; dropped ones pulse after in_last.
  assign trunc       = trs_q | ((state_q == S_WRITE) && tpend_q);

  // Buffer with the incoming char placed in slot idx_q (slot 0 is the MSB byte).
  always_comb begin
    w_buf_ins = buf_q;
    for (int s = 0; s < WORD_LENGTH; s++) begin
      if (idx_q == IW'(s)) begin
        w_buf_ins[(WORD_LENGTH-1-s)*DATA_WIDTH +: DATA_WIDTH] = in_char;
      end
    end
  end

  // Next-state logic: packing, single-cycle write, full-drop, clear override.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    tpend_d = tpend_q;
    cnt_d   = cnt_q;
    null_d  = 1'b0;
    ovf_d   = 1'b0;
    trs_d   = 1'b0;

    case (state_q)
      S_PACK: begin
        if (w_accept) begin
          if (idx_q != C_WL) begin
            buf_d = w_buf_ins;
            idx_d = idx_q + 1'b1;
          end else begin
            tpend_d = 1'b1;
          end
          if (in_last) begin
            if (w_buf_ins == '0) begin
              // All-zero is reserved as the null entry and never stored.
              null_d  = 1'b1;
              buf_d   = '0;
              idx_d   = '0;
              tpend_d = 1'b0;
`ifdef VOCAB_WRITER_STRICT_LEN_EN
            end else if (tpend_q || (idx_q == C_WL)) begin
              trs_d   = 1'b1;
              buf_d   = '0;
              idx_d   = '0;
              tpend_d = 1'b0;
`endif
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        buf_d   = '0;
        idx_d   = '0;
        tpend_d = 1'b0;
        state_d = ((cnt_q + 1'b1) == C_CAPACITY) ? S_FULL : S_PACK;
      end
      S_FULL: begin
        if (w_accept && in_last) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = S_PACK;
    endcase

    if (clear) begin
      state_d = S_PACK;
      cnt_d   = '0;
      buf_d   = '0;
      idx_d   = '0;
      tpend_d = 1'b0;
      null_d  = 1'b0;
      ovf_d   = 1'b0;
      trs_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PACK;
      buf_q   <= '0;
      idx_q   <= '0;
      tpend_q <= 1'b0;
      cnt_q   <= '0;
      null_q  <= 1'b0;
      ovf_q   <= 1'b0;
      trs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      tpend_q <= tpend_d;
      cnt_q   <= cnt_d;
      null_q  <= null_d;
      ovf_q   <= ovf_d;
      trs_q   <= trs_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/vocab_writer.md
Name: vocab_writer

Overview:
Builds the vocabulary memory that the matcher later scans. It accepts a character stream over a valid/ready handshake and packs each word into one WORD_LENGTH*DATA_WIDTH entry, first character in the most-significant byte and zero-padded. It appends the entry at the current end address and publishes the token id and the entry count. It is the write side of the vocab memory; the matcher is the read side and uses vocab_count as its end bound.

Parameters:
ADDR_WIDTH, 4, vocab address width; capacity = 2**ADDR_WIDTH entries
WORD_LENGTH, 3, characters per vocab entry
DATA_WIDTH, 8, bits per character

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
clear  in  1  synchronous vocab clear (count to 0, discard partial word)
in_valid  in  1  character valid
in_ready  out  1  character accepted when in_valid && in_ready
in_char  in  DATA_WIDTH  character
in_last  in  1  character is last of its word
mem_we  out  1  vocab memory write enable
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  WORD_LENGTH*DATA_WIDTH  packed entry
tok_valid  out  1  one-cycle pulse, new entry written
tok_id  out  ADDR_WIDTH  address of new entry, valid with tok_valid
vocab_count  out  ADDR_WIDTH+1  entries written, 0..2**ADDR_WIDTH
vocab_full  out  1  vocab_count == 2**ADDR_WIDTH
overflow  out  1  pulse: word dropped because vocab full
trunc  out  1  pulse: word longer than WORD_LENGTH, extra chars discarded
null_drop  out  1  pulse: packed word all-zero, not written (all-zero reserved as null entry)

Behaviour:
- Reset (rst=1 at posedge): state=PACK, buffer=0, char_idx=0, vocab_count=0. All pulses and mem_we are 0. in_ready=1 after the reset cycle. rst has priority over everything.
- PACK state: in_ready=1.
  - Each accepted char goes into byte slot char_idx; slot 0 = bits [WORD_LENGTH*DATA_WIDTH-1 -: DATA_WIDTH].
  - char_idx saturates at WORD_LENGTH. Chars accepted at saturation are discarded and set a sticky trunc_pending flag.
  - Accept with in_last:
    - final buffer (including this char) all-zero: null_drop pulses next cycle, no write, buffer cleared, stay PACK.
    - otherwise go to WRITE.
- WRITE state (exactly 1 cycle):
  - in_ready=0, mem_we=1, mem_addr=vocab_count[ADDR_WIDTH-1:0], mem_wdata=buffer.
  - tok_valid=1, tok_id=mem_addr; trunc=1 if trunc_pending.
  - Next cycle: vocab_count+1, buffer, char_idx and trunc_pending cleared.
  - Next state is FULL if the new count == 2**ADDR_WIDTH, else PACK.
- Latency: in_last accepted at edge N -> mem_we high in cycle N+1 -> next char accepted earliest at edge N+2.
- FULL state:
  - in_ready=1; chars are accepted and discarded; no mem_we.
  - overflow pulses the cycle after each accepted in_last.
  - vocab_full=1; vocab_count holds at 2**ADDR_WIDTH (no wrap).
- clear:
  - Sampled in any state: next state PACK, vocab_count=0, buffer/char_idx/trunc_pending cleared.
  - clear in the WRITE cycle: the write still happens (mem_we=1, tok_valid=1), but the count goes to 0, not +1.
  - clear together with an accepted char: the char is dropped.
- vocab_full is combinational from vocab_count. mem_we, tok_valid, overflow, trunc and null_drop are each high for exactly one cycle per event.

Optional Feature:
VOCAB_WRITER_STRICT_LEN_EN
- Defined: an over-long word is not written. At in_last, trunc pulses and the word is discarded exactly like a null word (no mem_we, no tok_valid, count unchanged).
- Undefined: the word is truncated to its first WORD_LENGTH chars, written, and trunc pulses with tok_valid.

Test Plan:
- Reset, then send "Hel" (0x48,0x65,0x6C, last on 0x6C) -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x48656C, tok_id=0; vocab_count becomes 1.
- Then send "Hi" -> mem_addr=1, mem_wdata=0x486900, tok_id=1, vocab_count=2; in_ready low only during the WRITE cycle.
- Send "Hello":
  - macro undefined -> mem_wdata=0x48656C at addr 2, trunc=1 with tok_valid.
  - macro defined -> no write, trunc pulse, vocab_count unchanged.
- Send single char 0x00 with last -> null_drop pulse, mem_we stays 0, vocab_count unchanged.
- Write 16 distinct words -> vocab_full=1, vocab_count=16. 17th word "Xyz" -> accepted, overflow pulses once, no mem_we. Then assert clear -> vocab_count=0; next word written to addr 0.
- Send 0x48,0x65 (no last), assert rst for one cycle, then send "ab" -> mem_wdata=0x616200 at addr 0 (partial word discarded).
